// File: rtl/ahb_slave_sram_responder.sv
// AHB slave responder backed by a flop-based word memory: programmable wait
// states on OKAY data phases and a two-cycle ERROR response for illegal accesses.
package AHB_package;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_type;
endpackage

// One byte lane of the word memory; the read port is asynchronous.
module ahb_sram_lane #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             hclk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge hclk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module ahb_slave_sram_responder
  import AHB_package::*;
#(
  parameter int                        AHB_ADDR_WIDTH = 32,
  parameter int                        AHB_DATA_WIDTH = 32,
  parameter int                        MEM_DEPTH      = 256,
  parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_1000,
  parameter int                        WAIT_STATES    = 1
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic                      hsel,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  htrans_type                htrans,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic [AHB_DATA_WIDTH-1:0] hwdata,
  input  logic                      hreadyin,
  output logic [AHB_DATA_WIDTH-1:0] hrdata,
  output logic                      hreadyout,
  output logic [1:0]                hresp
);
  localparam int                        NUM_LANES = AHB_DATA_WIDTH / 8;
  localparam int                        IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [AHB_ADDR_WIDTH-1:0] MEM_BYTES = AHB_ADDR_WIDTH'(MEM_DEPTH * 4);
  localparam logic [2:0]                WS_LAST   = 3'(WAIT_STATES - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic [2:0]       size;
    logic             write;
  } req_t;

  state_t                        state, next;
  req_t                          req;
  logic [2:0]                    cnt;
  logic [AHB_ADDR_WIDTH-1:0]     offset;
  logic                          acc, acc_err;
  logic [NUM_LANES-1:0]          be;
  logic [NUM_LANES-1:0][7:0]     wlanes, rlanes;

  assign offset = haddr - BASE_ADDR;
  assign acc    = hsel && hreadyin && hreadyout && (htrans == NONSEQ || htrans == SEQ);
  assign acc_err = (haddr < BASE_ADDR) || (offset >= MEM_BYTES) || (hsize > 3'd2) ||
                   (hsize == 3'd1 && haddr[0]) || (hsize == 3'd2 && haddr[1:0] != 2'b00);

  always_ff @(posedge hclk or posedge hreset)
    if (hreset) state <= ST_IDLE;
    else        state <= next;

  always_comb begin
    next = state;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2:
        if (acc)           next = acc_err ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_DATA);
        else               next = ST_IDLE;
      ST_WAIT: if (cnt == WS_LAST) next = ST_DATA;
      ST_ERR1:             next = ST_ERR2;
      default:             next = ST_IDLE;
    endcase
  end

  // Counter only runs in WAIT and clears on the way out.
  always_ff @(posedge hclk or posedge hreset)
    if (hreset)                                     cnt <= '0;
    else if (state == ST_WAIT && next != ST_WAIT)   cnt <= '0;
    else if (state == ST_WAIT)                      cnt <= cnt + 3'd1;

  always_ff @(posedge hclk or posedge hreset)
    if (hreset)   req <= '0;
    else if (acc) req <= '{idx: offset[IDX_W+1:2], lane: haddr[1:0], size: hsize, write: hwrite};

  always_comb begin
    case (req.size)
      3'd0:    be = NUM_LANES'(1) << req.lane;
      3'd1:    be = NUM_LANES'(3) << {req.lane[1], 1'b0};
      default: be = '1;
    endcase
  end

  assign wlanes = hwdata;

  // Errored transfers never reach DATA, so they can never write.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ahb_sram_lane #(.DEPTH(MEM_DEPTH), .IDX_W(IDX_W)) u_lane (
      .hclk  (hclk),
      .we    (state == ST_DATA && req.write && be[i]),
      .idx   (req.idx),
      .wdata (wlanes[i]),
      .rdata (rlanes[i])
    );
  end

  assign hreadyout = !(state == ST_WAIT || state == ST_ERR1);
  assign hresp     = (state == ST_ERR1 || state == ST_ERR2) ? 2'b01 : 2'b00;
  assign hrdata    = ((state == ST_WAIT || state == ST_DATA) && !req.write) ? rlanes : '0;
endmodule
